imem_boot_loader: RTL and testbench

Upstream loader for the single-cycle RISC-V processor. It receives a program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions. It writes them sequentially into instruction memory starting at byte address 0, and holds the processor in reset until a checksummed image has loaded completely. On a malformed image it stays in an error state with the processor held in reset.

---
 rtl/imem_boot_loader.sv | 103 ++++++++++
 tb/tb_imem_boot_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles little-endian words into instruction memory
// and holds the processor in reset until a length-checked, checksummed image lands.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [63:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t              state, state_next;
  logic [7:0]          len_lo;
  logic [15:0]         len;
  logic [1:0]          lane;
  logic [31:0]         word;
  logic [7:0]          csum;
  logic                xfer;
  logic [15:0]         len_in;
  logic                len_bad;
  logic [ADDR_WIDTH:0] wc_inc;

  assign xfer    = byte_valid & byte_ready;
  assign len_in  = {byte_data, len_lo};
  assign len_bad = (len_in == 16'd0) || ({1'b0, len_in} > MAX_WORDS);
  assign wc_inc  = word_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LEN_LO;
      S_LEN_LO: if (xfer) state_next = S_LEN_HI;
      S_LEN_HI: if (xfer) state_next = len_bad ? S_ERROR : S_DATA;
      S_DATA:   if (xfer && lane == 2'd3) state_next = S_WRITE;
      S_WRITE:  state_next = (16'(wc_inc) == len) ? S_CSUM : S_DATA;
      S_CSUM:   if (xfer) state_next = (byte_data == csum) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR:  if (start) state_next = S_LEN_LO;
      default:  state_next = S_IDLE;
    endcase
  end

  // All outputs decode from state or registers, so byte_ready never depends on byte_valid.
  always_comb begin
    byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                 (state == S_DATA)   || (state == S_CSUM);
    imem_we    = (state == S_WRITE);
    done       = (state == S_DONE);
    error      = (state == S_ERROR);
    cpu_reset  = (state != S_DONE);
    imem_addr  = 64'(word_count) << 2;
    imem_wdata = word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_lo     <= '0;
      len        <= '0;
      lane       <= '0;
      word       <= '0;
      csum       <= '0;
      word_count <= '0;
    end else begin
      case (state)
        S_LEN_LO: if (xfer) len_lo <= byte_data;
        S_LEN_HI: if (xfer) begin
          len        <= len_in;
          lane       <= '0;
          csum       <= '0;
          word_count <= '0;
        end
        S_DATA: if (xfer) begin
          word[{lane, 3'b000} +: 8] <= byte_data;
          csum                      <= csum ^ byte_data;
          lane                      <= lane + 2'd1;
        end
        S_WRITE: word_count <= wc_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: randomized images with valid gaps,
// checked against an image-level model of expected writes and final status.
module tb_imem_boot_loader;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, cpu_reset, done, error;
  logic [63:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .word_count(word_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [31:0] data; } wr_t;

  int          n_checks = 0;
  int          n_errors = 0;
  wr_t         exp_wr[$];
  logic [7:0]  stream[$];
  logic [31:0] words[$];
  int          start_at = -1;
  bit          gaps = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the next expected (addr, data) pair in order.
  always @(negedge clk) begin
    wr_t w;
    if (imem_we === 1'b1) begin
      chk("ready_in_write", byte_ready, 0);
      if (exp_wr.size() == 0) chk("unexpected_we", imem_addr, 64'hFFFF_FFFF);
      else begin
        w = exp_wr.pop_front();
        chk("we_addr", imem_addr, w.addr);
        chk("we_data", imem_wdata, w.data);
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_word_count", word_count, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
  endtask

  // Builds the byte stream and expected writes for an N-word image.
  task automatic build_image(input int n, input bit good, input bit use_words);
    logic [7:0] x = 8'h00;
    bit len_ok = (n >= 1) && (n <= (1 << AW));
    if (!use_words) begin
      words = {};
      for (int i = 0; i < n && len_ok; i++) words.push_back($urandom);
    end
    stream = {};
    exp_wr = {};
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    if (len_ok) begin
      for (int i = 0; i < n; i++) begin
        for (int b = 0; b < 4; b++) begin
          logic [31:0] wv = words[i];
          stream.push_back(wv[8*b +: 8]);
          x ^= wv[8*b +: 8];
        end
        exp_wr.push_back('{64'(4 * i), words[i]});
      end
      stream.push_back(good ? x : (x ^ 8'h01));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_done_clr", done, 0);
    chk("start_error_clr", error, 0);
    chk("start_cpu_reset", cpu_reset, 1);
  endtask

  // Returns right after the posedge on which the last byte transferred.
  task automatic send_stream();
    int idx = 0;
    int cyc = 0;
    while (idx < stream.size() && cyc < 5000) begin
      bit take;
      @(negedge clk);
      start = (start_at >= 0) && (idx == start_at);
      if (gaps && $urandom_range(0, 3) == 0) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = stream[idx];
      end
      take = byte_valid && byte_ready;
      @(posedge clk);
      if (take) idx++;
      cyc++;
    end
    if (idx < stream.size()) chk("stream_timeout", idx, stream.size());
  endtask

  task automatic run_image(input int n, input bit good, input bit use_words,
                           input bit gaps_i, input int start_at_i);
    bit len_ok = (n >= 1) && (n <= (1 << AW));
    bit ok     = len_ok && good;
    build_image(n, good, use_words);
    pulse_start();
    gaps = gaps_i;
    start_at = start_at_i;
    send_stream();
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b0;
    start_at = -1;
    chk("fin_done", done, ok);
    chk("fin_error", error, !ok);
    chk("fin_cpu_reset", cpu_reset, !ok);
    chk("fin_byte_ready", byte_ready, 0);
    chk("fin_word_count", word_count, len_ok ? n : 0);
    chk("fin_writes_left", exp_wr.size(), 0);
    repeat (2) @(negedge clk);
    chk("hold_done", done, ok);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;

    words = {32'h00500093, 32'h00A00113};
    run_image(2, 1, 1, 0, -1);
    words = {32'h00500093, 32'h00A00113};
    run_image(2, 0, 1, 0, -1);
    run_image(0, 1, 0, 0, -1);
    run_image(65, 1, 0, 0, -1);
    run_image(64, 1, 0, 1, -1);

    for (int k = 0; k < 8; k++)
      run_image($urandom_range(1, 20), $urandom_range(0, 3) != 0, 0, k[0],
                (k % 3 == 0) ? $urandom_range(0, 5) : -1);

    // Reset after 6 payload bytes: only the first word may be written.
    build_image(3, 1, 0);
    stream = stream[0:7];
    exp_wr = exp_wr[0:0];
    pulse_start();
    gaps = 1;
    send_stream();
    @(negedge clk);
    byte_valid = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_more_writes", exp_wr.size(), 0);
    chk("rst_stays_idle", byte_ready, 0);
    run_image(3, 1, 0, 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
